// File: rtl/setter_display_tx_pkg.sv
// setter_display_tx_pkg: shared FSM encoding and seven-segment patterns
package setter_display_tx_pkg;
   localparam int SEG_BITS = 8;
   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;
   // {dp,g,f,e,d,c,b,a}, indexed by hex digit
   localparam logic [SEG_BITS-1:0] SEG_MAP [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };
endpackage

// File: rtl/setter_display_tx_if.sv
// setter_display_tx_if: setter value/strobe in, 595-chain serial lines and status out
interface setter_display_tx_if;
   logic [7:0] data;
   logic update;
   logic ser_clk;
   logic ser_data;
   logic ser_latch;
   logic busy;
   logic done;
   modport master (output data, update, input ser_clk, ser_data, ser_latch, busy, done);
   modport slave (input data, update, output ser_clk, ser_data, ser_latch, busy, done);
endinterface

// File: rtl/setter_display_tx_hex_to_seg7.sv
// hex_to_seg7: one hex nibble to a seven-segment pattern, optionally inverted
module hex_to_seg7
   import setter_display_tx_pkg::*;
#(
   parameter logic ACTIVE_LOW = 1'b0
) (
   input  logic [3:0]          nibble,
   output logic [SEG_BITS-1:0] seg
);
   assign seg = SEG_MAP[nibble] ^ {SEG_BITS{ACTIVE_LOW}};
endmodule

// File: rtl/setter_display_tx.sv
// setter_display_tx: shifts the two-digit segment frame into a 595 chain on each update edge
module setter_display_tx
   import setter_display_tx_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input logic clk,
   input logic reset,
   setter_display_tx_if.slave bus
);
   state_t state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [3:0] idx, idx_nx;
   logic [15:0] frame, frame_nx, pend_frame, cap;
   logic pend, update_prev, rise, last, done_r, done_nx;
   hex_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_hi (.nibble(bus.data[7:4]), .seg(cap[15:8]));
   hex_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_lo (.nibble(bus.data[3:0]), .seg(cap[7:0]));
   assign rise = bus.update & ~update_prev;
   assign last = cnt == 8'(CLK_DIV - 1);
   always_comb begin
      state_nx = state;
      cnt_nx = last ? 8'd0 : cnt + 8'd1;
      idx_nx = idx;
      frame_nx = frame;
      done_nx = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = 8'd0;
            if (rise | pend) begin
               state_nx = SETUP;
               idx_nx = 4'd15;
               frame_nx = rise ? cap : pend_frame;
            end
         end
         SETUP: state_nx = last ? HIGH : SETUP;
         HIGH: if (last) begin
            state_nx = idx == 4'd0 ? LATCH : SETUP;
            idx_nx = idx == 4'd0 ? idx : idx - 4'd1;
         end
         LATCH: if (last) begin
            state_nx = IDLE;
            done_nx = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   // Edges seen mid-frame park here; the newest capture wins and IDLE picks it up
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= 8'd0;
         idx <= 4'd0;
         frame <= 16'd0;
         pend <= 1'b0;
         pend_frame <= 16'd0;
         update_prev <= 1'b1;
         done_r <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         idx <= idx_nx;
         frame <= frame_nx;
         pend <= state == IDLE ? 1'b0 : pend | rise;
         pend_frame <= (state != IDLE && rise) ? cap : pend_frame;
         update_prev <= bus.update;
         done_r <= done_nx;
      end
   end
   assign bus.ser_clk = state == HIGH;
   assign bus.ser_data = (state == SETUP || state == HIGH) & frame[idx];
   assign bus.ser_latch = state == LATCH;
   assign bus.busy = state != IDLE;
   assign bus.done = done_r;
endmodule
